// File: rtl/inst_mem_loader_if.sv
// Byte-stream input and instruction-RAM write port of the instruction memory loader.
// master = loader side, slave = stream source / RAM side.
interface inst_mem_loader_if #(
  parameter int ADDR_W = 6
);
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;

  modport master (
    input  byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_din
  );

  modport slave (
    output byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/inst_mem_loader.sv
// Instruction memory loader: packs a little-endian byte stream into 32-bit words,
// writes them sequentially into the instruction RAM and holds the CPU during the load.
module inst_mem_loader #(
  parameter int ADDR_W     = 6,
  parameter int WORD_COUNT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  inst_mem_loader_if.master bus,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORD_COUNT - 1);
  localparam logic [ADDR_W:0]   WORD_MAX  = (ADDR_W + 1)'(WORD_COUNT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] addr_r;
  logic [1:0]        cnt_r;
  logic [31:0]       word_r;

  // Load sequencer: state, byte assembly and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= IDLE;
      addr_r         <= '0;
      cnt_r          <= 2'd0;
      word_r         <= 32'd0;
      bus.byte_ready <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_din    <= 32'd0;
      cpu_hold       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      words_loaded   <= '0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          bus.mem_we <= 1'b0;
          // abort in the same cycle suppresses start
          if (start && !abort) begin
            state_r        <= COLLECT;
            addr_r         <= '0;
            cnt_r          <= 2'd0;
            bus.byte_ready <= 1'b1;
            cpu_hold       <= 1'b1;
            busy           <= 1'b1;
            done           <= 1'b0;
            err            <= 1'b0;
            words_loaded   <= '0;
          end else begin
            state_r <= state_r;
          end
        end

        COLLECT: begin
          bus.mem_we <= 1'b0;
          if (abort) begin
            state_r        <= IDLE;
            cnt_r          <= 2'd0;
            bus.byte_ready <= 1'b0;
            busy           <= 1'b0;
            err            <= 1'b1;
          end else if (bus.byte_valid && bus.byte_ready) begin
            word_r[8*cnt_r +: 8] <= bus.byte_in;
            cnt_r                <= cnt_r + 2'd1;
            if (cnt_r == 2'd3) begin
              // fourth byte goes straight into the write data, no extra cycle
              state_r        <= WRITE;
              bus.byte_ready <= 1'b0;
              bus.mem_we     <= 1'b1;
              bus.mem_addr   <= addr_r;
              bus.mem_din    <= {bus.byte_in, word_r[23:0]};
            end else begin
              state_r <= COLLECT;
            end
          end else begin
            state_r <= COLLECT;
          end
        end

        WRITE: begin
          bus.mem_we <= 1'b0;
          if (abort) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            err     <= 1'b1;
          end else begin
            if (words_loaded < WORD_MAX) begin
              words_loaded <= words_loaded + (ADDR_W + 1)'(1);
            end else begin
              words_loaded <= words_loaded;
            end
            if (addr_r == LAST_ADDR) begin
              state_r        <= DONE;
              bus.byte_ready <= 1'b0;
              cpu_hold       <= 1'b0;
              busy           <= 1'b0;
              done           <= 1'b1;
            end else begin
              state_r        <= COLLECT;
              addr_r         <= addr_r + ADDR_W'(1);
              bus.byte_ready <= 1'b1;
            end
          end
        end

        default: begin
          state_r        <= IDLE;
          bus.byte_ready <= 1'b0;
          bus.mem_we     <= 1'b0;
          busy           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: a 64-word instance plus a 2-word instance
// sharing clock, reset and byte stream; a RAM model captures every write.
module tb_inst_mem_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_b = 1'b0;
  logic       start_s = 1'b0;
  logic       abort = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_in = 8'd0;
  logic       sel_s = 1'b0;

  logic       cpu_hold_b, busy_b, done_b, err_b;
  logic       cpu_hold_s, busy_s, done_s, err_s;
  logic [6:0] wl_b, wl_s;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram_b [64];
  logic [31:0] ram_s [2];
  int we_b = 0;
  int we_s = 0;
  int busy_cycles = 0;
  int seq_errs = 0;
  int load_base = 0;

  always #5 clk = ~clk;

  inst_mem_loader_if #(.ADDR_W(6)) bus_b ();
  inst_mem_loader_if #(.ADDR_W(6)) bus_s ();

  assign bus_b.byte_in    = byte_in;
  assign bus_b.byte_valid = byte_valid;
  assign bus_s.byte_in    = byte_in;
  assign bus_s.byte_valid = byte_valid;

  inst_mem_loader #(.ADDR_W(6), .WORD_COUNT(64)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort), .bus(bus_b),
    .cpu_hold(cpu_hold_b), .busy(busy_b), .done(done_b), .err(err_b),
    .words_loaded(wl_b)
  );

  inst_mem_loader #(.ADDR_W(6), .WORD_COUNT(2)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .abort(1'b0), .bus(bus_s),
    .cpu_hold(cpu_hold_s), .busy(busy_s), .done(done_s), .err(err_s),
    .words_loaded(wl_s)
  );

  // RAM model and write-order tracking, sampled mid-cycle
  always @(negedge clk) begin
    if (bus_b.mem_we === 1'b1) begin
      ram_b[bus_b.mem_addr] <= bus_b.mem_din;
      we_b <= we_b + 1;
      if (bus_b.mem_addr !== 6'(we_b - load_base)) seq_errs <= seq_errs + 1;
    end
    if (bus_s.mem_we === 1'b1) begin
      ram_s[bus_s.mem_addr[0]] <= bus_s.mem_din;
      we_s <= we_s + 1;
    end
    if (busy_b === 1'b1) busy_cycles <= busy_cycles + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int n;
    if (gap > 0) begin
      byte_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    byte_in    = b;
    byte_valid = 1'b1;
    n = 0;
    while (((sel_s ? bus_s.byte_ready : bus_b.byte_ready) !== 1'b1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $error("FAIL ready_timeout observed=%0d expected=<20", n);
    end
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (((sel_s ? busy_s : busy_b) !== 1'b0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 64'(n < 50), 64'd1);
  endtask

  task automatic pulse_start_b();
    load_base = we_b;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
  endtask

  initial begin
    int base_we;
    int base_seq;
    int bc0;
    int mism;
    logic [31:0] e;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ctrl", {bus_b.byte_ready, bus_b.mem_we, cpu_hold_b, busy_b, done_b, err_b}, 64'd0);
    chk("rst_data", {bus_b.mem_addr, bus_b.mem_din, wl_b}, 64'd0);

    // 1: two-word load into the small instance
    sel_s = 1'b1;
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    chk("t1_hold_busy_ready", {cpu_hold_s, busy_s, bus_s.byte_ready}, 64'b111);
    send(8'h00, 0); send(8'h00, 0); send(8'h00, 0); send(8'h20, 0);
    send(8'h13, 0); send(8'h05, 0); send(8'h00, 0); send(8'h00, 0);
    byte_valid = 1'b0;
    wait_idle();
    chk("t1_word0", ram_s[0], 64'h2000_0000);
    chk("t1_word1", ram_s[1], 64'h0000_0513);
    chk("t1_we_count", we_s, 64'd2);
    chk("t1_done_hold", {done_s, cpu_hold_s, wl_s}, {62'd0, 1'b1, 1'b0} << 7 | 64'd2);
    sel_s = 1'b0;

    // 2: full 64-word load, back-to-back bytes
    base_we  = we_b;
    base_seq = seq_errs;
    bc0      = busy_cycles;
    pulse_start_b();
    for (int i = 0; i < 256; i++) send(8'(i), 0);
    byte_valid = 1'b0;
    wait_idle();
    mism = 0;
    for (int i = 0; i < 64; i++) begin
      e = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      if (ram_b[i] !== e) mism++;
    end
    chk("t2_image_mismatches", mism, 64'd0);
    chk("t2_word63", ram_b[63], 64'hFFFE_FDFC);
    chk("t2_we_count", we_b - base_we, 64'd64);
    chk("t2_addr_order", seq_errs - base_seq, 64'd0);
    chk("t2_busy_cycles", busy_cycles - bc0, 64'd320);
    chk("t2_done_hold_err", {done_b, cpu_hold_b, err_b}, 64'b100);
    chk("t2_words_loaded", wl_b, 64'd64);
    chk("t2_held_addr_din", {bus_b.mem_addr, bus_b.mem_din}, {26'd0, 6'd63, 32'hFFFE_FDFC});

    // 3: same image with random gaps in byte_valid
    base_we = we_b;
    pulse_start_b();
    chk("t3_start_clears", {done_b, busy_b, wl_b}, 64'b0_1_0000000 << 0 | 64'h80);
    for (int i = 0; i < 256; i++) send(8'(i), int'($urandom_range(0, 2)));
    byte_valid = 1'b0;
    wait_idle();
    mism = 0;
    for (int i = 0; i < 64; i++) begin
      e = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      if (ram_b[i] !== e) mism++;
    end
    chk("t3_image_mismatches", mism, 64'd0);
    chk("t3_we_count", we_b - base_we, 64'd64);
    chk("t3_addr_order", seq_errs - base_seq, 64'd0);

    // 4: abort after six bytes, then reload from address 0
    base_we = we_b;
    pulse_start_b();
    for (int i = 0; i < 6; i++) send(8'h10 + 8'(i), 0);
    abort = 1'b1;
    byte_valid = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    chk("t4_err_hold_busy_ready", {err_b, cpu_hold_b, busy_b, bus_b.byte_ready}, 64'b1100);
    chk("t4_words_loaded", wl_b, 64'd1);
    chk("t4_we_count", we_b - base_we, 64'd1);
    chk("t4_word0", ram_b[0], 64'h1312_1110);
    byte_valid = 1'b1;
    repeat (5) @(negedge clk);
    byte_valid = 1'b0;
    chk("t4_idle_no_write", {busy_b, 32'(we_b - base_we)}, 64'd1);
    base_we = we_b;
    pulse_start_b();
    chk("t4_restart_clears", {err_b, wl_b}, 64'd0);
    send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0); send(8'hDD, 0);
    byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("t4_reload_word0", ram_b[0], 64'hDDCC_BBAA);

    // 5: start during COLLECT ignored; start+abort together aborts
    send(8'h01, 0);
    byte_valid = 1'b0;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
    send(8'h55, 0); send(8'h66, 0);
    byte_valid = 1'b0;
    abort   = 1'b1;
    start_b = 1'b1;
    @(negedge clk);
    abort   = 1'b0;
    start_b = 1'b0;
    chk("t5_word1", ram_b[1], 64'h0403_0201);
    chk("t5_we_count", we_b - base_we, 64'd2);
    chk("t5_addr_order", seq_errs - base_seq, 64'd0);
    chk("t5_abort_wins", {err_b, busy_b, cpu_hold_b, wl_b}, {61'd0, 3'b101} << 7 | 64'd2);

    // 6: reset between 2nd and 3rd byte of word 5
    base_we = we_b;
    pulse_start_b();
    for (int i = 0; i < 22; i++) send(8'h80 + 8'(i), 0);
    chk("t6_words_before_rst", wl_b, 64'd5);
    rst = 1'b1;
    #1;
    chk("t6_async_ctrl", {bus_b.byte_ready, bus_b.mem_we, cpu_hold_b, busy_b, done_b, err_b}, 64'd0);
    chk("t6_async_data", {bus_b.mem_addr, bus_b.mem_din, wl_b}, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    byte_valid = 1'b0;
    chk("t6_no_more_writes", we_b - base_we, 64'd5);
    chk("t6_word4", ram_b[4], 64'h9392_9190);
    chk("t6_idle_after", {busy_b, cpu_hold_b}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
